// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable data width, stop length and parity.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_param #(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            i_Clock,
  input  logic            i_reset,
  input  logic            i_bd,
  input  logic            i_Rx_Serial,
  output logic            o_Rx_Done,
  output logic [DBIT-1:0] o_Rx_Byte,
  output logic            o_Frame_Err,
  output logic            o_Parity_Err
);

  localparam int TICK_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW       = $clog2(TICK_MAX);
  localparam int BW       = $clog2(DBIT + 1);

  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVS - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            fe_pend_q, fe_pend_d;
  logic [DBIT-1:0] byte_q, byte_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            stop_low;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic pe_pend_q, pe_pend_d;
  logic perr_q, perr_d;
`endif

  // Synchroniser and state registers
  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      fe_pend_q <= 1'b0;
      byte_q    <= '0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pend_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta   <= i_Rx_Serial;
      rx_s      <= rx_meta;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      fe_pend_q <= fe_pend_d;
      byte_q    <= byte_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
`ifdef UART_RX_PARITY_EN
      pe_pend_q <= pe_pend_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state and output-register logic
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    fe_pend_d = fe_pend_q;
    byte_d    = byte_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    stop_low  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_pend_d = pe_pend_q;
    perr_d    = perr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d   = S_START;
          tick_d    = '0;
          fe_pend_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          pe_pend_d = 1'b0;
`endif
        end
      end

      S_START: begin
        if (i_bd) begin
          if (tick_q == T_MID) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + T_ONE;
          end
        end
      end

      S_DATA: begin
        if (i_bd) begin
          if (tick_q == T_BIT) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + B_ONE;
            end
          end else begin
            tick_d = tick_q + T_ONE;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_bd) begin
          if (tick_q == T_BIT) begin
            tick_d  = '0;
            state_d = S_STOP;
            if (rx_s != ((^shreg_q) ^ PAR_ODD)) pe_pend_d = 1'b1;
          end else begin
            tick_d = tick_q + T_ONE;
          end
        end
      end
`endif

      S_STOP: begin
        if (i_bd) begin
          // Stop centre and stop end coincide when SB_TICK == OVS
          stop_low = (tick_q == T_BIT) && !rx_s;
          if (stop_low) fe_pend_d = 1'b1;
          if (tick_q == T_STOP) begin
            state_d = S_IDLE;
            tick_d  = '0;
            byte_d  = shreg_q;
            ferr_d  = fe_pend_q | stop_low;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = pe_pend_q;
`endif
          end else begin
            tick_d = tick_q + T_ONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_Rx_Done   = done_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: directed and random frames on two parameterisations against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int OVS     = 16;
  localparam int DB_A    = 8;
  localparam int SB_A    = 16;
  localparam int DB_B    = 7;
  localparam int SB_B    = 32;
  localparam int PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      div = 2'd0;
  logic            bd;
  logic            line_a = 1'b1;
  logic            line_b = 1'b1;
  logic            done_a, fe_a, pe_a;
  logic            done_b, fe_b, pe_b;
  logic [DB_A-1:0] byte_a;
  logic [DB_B-1:0] byte_b;

  int total = 0;
  int bad   = 0;
  int ndone_a = 0, ndone_b = 0;
  int exp_a = 0, exp_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign bd = (div == 2'd3);

  always @(posedge clk) begin
    if (done_a) ndone_a <= ndone_a + 1;
    if (done_b) ndone_b <= ndone_b + 1;
  end

  uart_rx_param #(.DBIT(DB_A), .OVS(OVS), .SB_TICK(SB_A), .PARITY_ODD(PAR_ODD)) dut_a (
    .i_Clock(clk), .i_reset(rst), .i_bd(bd), .i_Rx_Serial(line_a),
    .o_Rx_Done(done_a), .o_Rx_Byte(byte_a), .o_Frame_Err(fe_a), .o_Parity_Err(pe_a)
  );

  uart_rx_param #(.DBIT(DB_B), .OVS(OVS), .SB_TICK(SB_B), .PARITY_ODD(PAR_ODD)) dut_b (
    .i_Clock(clk), .i_reset(rst), .i_bd(bd), .i_Rx_Serial(line_b),
    .o_Rx_Done(done_b), .o_Rx_Byte(byte_b), .o_Frame_Err(fe_b), .o_Parity_Err(pe_b)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_byte(input int w);
    return (w == 0) ? 32'(byte_a) : 32'(byte_b);
  endfunction
  function automatic logic [31:0] out_done(input int w);
    return (w == 0) ? 32'(done_a) : 32'(done_b);
  endfunction
  function automatic logic [31:0] out_fe(input int w);
    return (w == 0) ? 32'(fe_a) : 32'(fe_b);
  endfunction
  function automatic logic [31:0] out_pe(input int w);
    return (w == 0) ? 32'(pe_a) : 32'(pe_b);
  endfunction

  task automatic wait_tick();
    @(negedge clk);
    while (!bd) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 0) line_a = v;
    else        line_b = v;
  endtask

  // Drives one frame tick by tick; done is expected right after the last tick of the frame.
  task automatic send_frame(input int w, input logic [8:0] data, input logic stop_v,
                            input logic par_flip, input int abort_k);
    int db, sb, len, slot;
    logic [8:0] mask;
    logic pbit;
    string nm;
    db   = (w == 0) ? DB_A : DB_B;
    sb   = (w == 0) ? SB_A : SB_B;
    len  = (1 + db + P) * OVS - OVS / 2 + sb;
    mask = 9'((1 << db) - 1);
    pbit = (^(data & mask)) ^ 1'(PAR_ODD) ^ par_flip;
    nm   = (w == 0) ? "a" : "b";
    wait_tick();
    set_line(w, 1'b0);
    for (int k = 1; k <= len; k++) begin
      wait_tick();
      if (k == abort_k) begin
        rst = 1'b1;
        set_line(w, 1'b1);
        #1;
        check({nm, "_rst_byte"}, out_byte(w), 32'd0);
        check({nm, "_rst_done"}, out_done(w), 32'd0);
        check({nm, "_rst_fe"},   out_fe(w),   32'd0);
        check({nm, "_rst_pe"},   out_pe(w),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k % OVS == 0) begin
        slot = k / OVS;
        if (slot <= db)                       set_line(w, data[slot-1]);
        else if (P == 1 && slot == db + 1)    set_line(w, pbit);
        else                                  set_line(w, stop_v);
      end
    end
    check({nm, "_done_early"}, out_done(w), 32'd0);
    set_line(w, 1'b1);
    @(negedge clk);
    check({nm, "_done"}, out_done(w), 32'd1);
    check({nm, "_byte"}, out_byte(w), 32'(data & mask));
    check({nm, "_fe"},   out_fe(w),   32'(!stop_v));
    check({nm, "_pe"},   out_pe(w),   (P == 1) ? 32'(par_flip) : 32'd0);
    if (w == 0) exp_a++;
    else        exp_b++;
    @(negedge clk);
    check({nm, "_done_fall"}, out_done(w), 32'd0);
    check({nm, "_done_count"}, (w == 0) ? 32'(ndone_a) : 32'(ndone_b),
          (w == 0) ? 32'(exp_a) : 32'(exp_b));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_byte_a", out_byte(0), 32'd0);
    check("reset_done_a", out_done(0), 32'd0);
    check("reset_fe_a",   out_fe(0),   32'd0);
    check("reset_pe_a",   out_pe(0),   32'd0);
    check("reset_byte_b", out_byte(1), 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    send_frame(0, 9'h055, 1'b1, 1'b0, 0);
    send_frame(0, 9'h0A3, 1'b1, 1'b0, 0);

    wait_tick();
    line_a = 1'b0;
    wait_ticks(4);
    line_a = 1'b1;
    wait_ticks(24);
    check("glitch_count", 32'(ndone_a), 32'(exp_a));
    check("glitch_byte",  out_byte(0), 32'h0A3);
    check("glitch_fe",    out_fe(0),   32'd0);
    send_frame(0, 9'h03C, 1'b1, 1'b0, 0);

    send_frame(0, 9'h081, 1'b0, 1'b0, 0);
    wait_ticks(OVS);
    check("ferr_hold_count", 32'(ndone_a), 32'(exp_a));
    check("ferr_hold_fe",    out_fe(0),    32'd1);
    send_frame(0, 9'h07E, 1'b1, 1'b0, 0);

    send_frame(0, 9'h007, 1'b1, 1'b0, 0);
    send_frame(0, 9'h007, 1'b1, 1'b1, 0);

    send_frame(1, 9'h05A, 1'b1, 1'b0, 0);

    send_frame(0, 9'h0FF, 1'b1, 1'b0, 5 * OVS + OVS / 2);
    check("rst_byte_b", out_byte(1), 32'd0);
    wait_ticks(4);
    check("rst_count", 32'(ndone_a), 32'(exp_a));
    send_frame(0, 9'h012, 1'b1, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(0, 9'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)), 0);
      wait_ticks($urandom_range(0, 3));
    end
    for (int i = 0; i < 3; i++) begin
      send_frame(1, 9'($urandom_range(0, 127)), 1'b1, 1'($urandom_range(0, 1)), 0);
      wait_ticks($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
